// File: rtl/apb_pkg.sv
// Shared types and defaults for the two-port APB master arbiter.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int A_WIDTH_DEF = 8;
  localparam int D_WIDTH_DEF = 8;

  // One-hot completion vector for a granted requester index.
  function automatic logic [1:0] grant_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter: grants the requester not served last when
// both are pending, otherwise whichever one is pending.
module apb_rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic       grant_o,
  output logic       any_o
);

  // Grant selection from pending requests and last-served pointer.
  always_comb begin
    any_o   = |valid_i;
    grant_o = 1'b0;
    case (valid_i)
      2'b11:   grant_o = ~last_i;
      2'b10:   grant_o = 1'b1;
      2'b01:   grant_o = 1'b0;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/apb_master_arb.sv
// Two-port APB master: round-robin arbitration between two requesters,
// SETUP/ACCESS sequencing, wait-state handling and timeout abort.
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                 p_clk,
  input  logic                 p_rst,
  input  logic [1:0]           req_valid,
  input  logic [1:0]           req_write,
  input  logic [2*A_WIDTH-1:0] req_addr,
  input  logic [2*D_WIDTH-1:0] req_wdata,
  output logic [1:0]           req_done,
  output logic                 req_err,
  output logic [D_WIDTH-1:0]   req_rdata,
  output logic                 busy,
  output logic                 p_sel,
  output logic                 p_enable,
  output logic                 p_write,
  output logic [A_WIDTH-1:0]   p_addr,
  output logic [D_WIDTH-1:0]   wr_data,
  input  logic [D_WIDTH-1:0]   rd_data,
  input  logic                 p_ready
);

  localparam int CNT_W = $clog2(TIMEOUT);

  apb_state_e           state_q, state_d;
  logic                 last_q, last_d;
  logic                 gnt_q, gnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 p_write_q, p_write_d;
  logic [A_WIDTH-1:0]   p_addr_q, p_addr_d;
  logic [D_WIDTH-1:0]   wr_data_q, wr_data_d;

  logic                 arb_grant_s;
  logic                 arb_any_s;
  logic                 timeout_hit_s;
  logic                 done_s;

  apb_rr_arb2 u_arb (
    .valid_i (req_valid),
    .last_i  (last_q),
    .grant_o (arb_grant_s),
    .any_o   (arb_any_s)
  );

  assign timeout_hit_s = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State, grant bookkeeping and latched bus fields.
  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      cnt_q     <= '0;
      p_write_q <= 1'b0;
      p_addr_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      p_write_q <= p_write_d;
      p_addr_q  <= p_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state logic; request inputs are only sampled while IDLE so the
  // bus fields stay stable for the whole transfer.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    p_write_d = p_write_q;
    p_addr_d  = p_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (arb_any_s) begin
          state_d   = SETUP;
          gnt_d     = arb_grant_s;
          last_d    = arb_grant_s;
          cnt_d     = '0;
          p_write_d = req_write[arb_grant_s];
          p_addr_d  = arb_grant_s ? req_addr[2*A_WIDTH-1:A_WIDTH] : req_addr[A_WIDTH-1:0];
          wr_data_d = arb_grant_s ? req_wdata[2*D_WIDTH-1:D_WIDTH] : req_wdata[D_WIDTH-1:0];
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (p_ready) begin
          state_d = IDLE;
        end else if (timeout_hit_s) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Completion decode: a ready slave takes priority over the timeout.
  always_comb begin
    done_s    = (state_q == ACCESS) && (p_ready || timeout_hit_s);
    req_err   = (state_q == ACCESS) && !p_ready && timeout_hit_s;
    req_done  = 2'b00;
    req_rdata = '0;
    if (done_s) begin
      req_done = grant_onehot(gnt_q);
      if (!p_write_q && p_ready) begin
        req_rdata = rd_data;
      end else begin
        req_rdata = '0;
      end
    end else begin
      req_done = 2'b00;
    end
  end

  assign busy     = (state_q != IDLE);
  assign p_sel    = (state_q != IDLE);
  assign p_enable = (state_q == ACCESS);
  assign p_write  = p_write_q;
  assign p_addr   = p_addr_q;
  assign wr_data  = wr_data_q;

endmodule
